// File: rtl/pps_phase_meas_n.sv
`default_nettype none
// ============================================================================
// Module   : pps_phase_meas_n
// Purpose  : Multi-channel PPS phase/timestamp unit in the deserialiser
//            parallel clock domain. Each lane latches the epoch counter on
//            its first rising edge of the epoch. The lane captures are summed
//            per channel and reported as absolute sums, lane-complete flags
//            and signed differences against channel 0. Channel 0 lane 0
//            starts the result delay.
// Ports    : i_clk    - parallel sample clock
//            i_res    - synchronous active-high reset
//            i_dt     - CH*LANES samples, bit c*LANES+l = channel c, lane l
//                       (lane 0 is the earliest sample)
//            o_ph_en  - one-cycle result strobe
//            o_ph     - per-channel lane sum, channel c at [c*SUM_W +: SUM_W]
//            o_ph_vld - channel c had all lanes captured this epoch
//            o_dph    - signed sum[c]-sum[0], channel c at [c*DW +: DW]
//            o_busy   - epoch in progress (not ARMED)
// Revision : 1.0 - initial release
// ============================================================================
module pps_phase_meas_n #(
    parameter int CH      = 5,
    parameter int LANES   = 4,
    parameter int CNT_W   = 28,
    parameter int DLY_CYC = 25000000,
    localparam int SUM_W  = CNT_W + $clog2(LANES),
    localparam int DW     = SUM_W + 1
) (
    input  logic                  i_clk,
    input  logic                  i_res,
    input  logic [CH*LANES-1:0]   i_dt,
    output logic                  o_ph_en,
    output logic [CH*SUM_W-1:0]   o_ph,
    output logic [CH-1:0]         o_ph_vld,
    output logic [CH*DW-1:0]      o_dph,
    output logic                  o_busy
);

    localparam int NL    = CH * LANES;
    localparam int DLY_W = (DLY_CYC > 1) ? $clog2(DLY_CYC) : 1;
    localparam logic [DLY_W-1:0] c_DLY_LAST = DLY_W'(DLY_CYC - 1);

    localparam logic [1:0] c_ARMED = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_SUM   = 2'd2;
    localparam logic [1:0] c_OUT   = 2'd3;

    logic [1:0]       r_state;
    logic [NL-1:0]    r_prev;
    logic [NL-1:0]    r_pd;
    logic [NL-1:0]    r_flag;
    logic [CNT_W-1:0] r_cap [NL];
    logic [CNT_W-1:0] r_cnt;
    logic [DLY_W-1:0] r_dly;
    logic             r_ph_en;
    logic [SUM_W-1:0] r_ph  [CH];
    logic [CH-1:0]    r_vld;
    logic [DW-1:0]    r_dph [CH];

    logic [SUM_W-1:0] w_sum [CH];
    logic [CH-1:0]    w_all;
    logic [DW-1:0]    w_dph [CH];

    // Exact lane sums (SUM_W holds LANES full-scale captures without loss)
    // and differences against channel 0. Both sums are zero-extended to DW
    // before subtracting so the result is a correct two's complement value.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            w_sum[c] = '0;
            for (int l = 0; l < LANES; l++) begin
                w_sum[c] = w_sum[c] + SUM_W'(r_cap[c*LANES + l]);
            end
            w_all[c] = &r_flag[c*LANES +: LANES];
        end
        for (int c = 0; c < CH; c++) begin
            w_dph[c] = '0;
            if (w_all[c] && w_all[0]) begin
                w_dph[c] = DW'(w_sum[c]) - DW'(w_sum[0]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state <= c_ARMED;
            r_prev  <= '0;
            r_pd    <= '0;
            r_flag  <= '0;
            r_cnt   <= '0;
            r_dly   <= '0;
            r_ph_en <= 1'b0;
            r_vld   <= '0;
            for (int k = 0; k < NL; k++) r_cap[k] <= '0;
            for (int c = 0; c < CH; c++) begin
                r_ph[c]  <= '0;
                r_dph[c] <= '0;
            end
        end else begin
            r_prev  <= i_dt;
            r_pd    <= ~r_prev & i_dt;
            r_ph_en <= 1'b0;
            case (r_state)
                c_ARMED, c_WAIT: begin
                    // Counter saturates so late captures read all-ones.
                    if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
                    // Only the first edge per lane and epoch is kept.
                    for (int k = 0; k < NL; k++) begin
                        if (r_pd[k] && !r_flag[k]) begin
                            r_flag[k] <= 1'b1;
                            r_cap[k]  <= r_cnt;
                        end
                    end
                    if (r_state == c_ARMED) begin
                        if (r_pd[0]) begin
                            r_state <= c_WAIT;
                            r_dly   <= '0;
                        end
                    end else if (r_dly == c_DLY_LAST) begin
                        r_state <= c_SUM;
                    end else begin
                        r_dly <= r_dly + 1'b1;
                    end
                end
                c_SUM: begin
                    // Results land together with the strobe in the OUT cycle.
                    for (int c = 0; c < CH; c++) begin
                        r_ph[c]  <= w_sum[c];
                        r_dph[c] <= w_dph[c];
                    end
                    r_vld   <= w_all;
                    r_ph_en <= 1'b1;
                    r_state <= c_OUT;
                end
                c_OUT: begin
                    r_cnt   <= '0;
                    r_flag  <= '0;
                    for (int k = 0; k < NL; k++) r_cap[k] <= '0;
                    r_state <= c_ARMED;
                end
                default: r_state <= c_ARMED;
            endcase
        end
    end

    generate
        for (genvar c = 0; c < CH; c++) begin : g_pack
            assign o_ph[c*SUM_W +: SUM_W] = r_ph[c];
            assign o_dph[c*DW +: DW]      = r_dph[c];
        end
    endgenerate

    assign o_ph_en  = r_ph_en;
    assign o_ph_vld = r_vld;
    assign o_busy   = (r_state != c_ARMED);

endmodule
`default_nettype wire

// File: tb/tb_pps_phase_meas_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_pps_phase_meas_n
// Purpose  : Directed self-checking bench for pps_phase_meas_n with
//            CH=3, LANES=4, CNT_W=8, DLY_CYC=10 (SUM_W=10, DW=11).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pps_phase_meas_n;

    localparam int CH      = 3;
    localparam int LANES   = 4;
    localparam int CNT_W   = 8;
    localparam int DLY_CYC = 10;
    localparam int SUM_W   = 10;
    localparam int DW      = 11;

    logic                i_clk = 1'b0;
    logic                i_res = 1'b1;
    logic [CH*LANES-1:0] i_dt  = '0;
    logic                o_ph_en;
    logic [CH*SUM_W-1:0] o_ph;
    logic [CH-1:0]       o_ph_vld;
    logic [CH*DW-1:0]    o_dph;
    logic                o_busy;

    int checks = 0;
    int errors = 0;
    // Period index since the start of the current epoch; equals the DUT
    // epoch counter while it is ARMED/WAIT and not saturated.
    int per    = 0;

    pps_phase_meas_n #(
        .CH(CH), .LANES(LANES), .CNT_W(CNT_W), .DLY_CYC(DLY_CYC)
    ) dut (
        .i_clk(i_clk), .i_res(i_res), .i_dt(i_dt),
        .o_ph_en(o_ph_en), .o_ph(o_ph), .o_ph_vld(o_ph_vld),
        .o_dph(o_dph), .o_busy(o_busy)
    );

    always #2 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
        per++;
    endtask

    task automatic go_to(input int k);
        for (int n = 0; n < 400 && per < k; n++) tick();
    endtask

    task automatic do_reset;
        i_res = 1'b1;
        i_dt  = '0;
        tick();
        tick();
        i_res = 1'b0;
        per   = 0;
    endtask

    task automatic next_epoch;
        tick();
        per = 0;
    endtask

    task automatic wait_strobe(output int at);
        at = -1;
        for (int n = 0; n < 400 && at < 0; n++) begin
            if (o_ph_en === 1'b1) at = per;
            else tick();
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({o_ph, o_ph_vld, o_dph} !== '0) begin
            errors++;
            $display("FAIL reset_data: got ph=%h vld=%b dph=%h, expected all 0", o_ph, o_ph_vld, o_dph);
        end
        checks++;
        if ({o_ph_en, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: got en=%b busy=%b, expected 0 0", o_ph_en, o_busy);
        end
    endtask

    task automatic test_basic;
        int at;
        logic [CH*SUM_W-1:0] e_ph;
        e_ph = {10'd20, 10'd30, 10'd20};
        do_reset();
        go_to(4); i_dt[3:0] = 4'hF; i_dt[11:8] = 4'hF;
        go_to(6); i_dt[7:6] = 2'b11;
        go_to(7); i_dt[5:4] = 2'b11;
        go_to(8);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b, expected 1", o_busy);
        end
        wait_strobe(at);
        checks++;
        if (at != 17) begin
            errors++;
            $display("FAIL basic_latency: strobe at %0d, expected 17", at);
        end
        checks++;
        if (o_ph !== e_ph) begin
            errors++;
            $display("FAIL basic_ph: got %h, expected %h", o_ph, e_ph);
        end
        checks++;
        if (o_ph_vld !== 3'b111) begin
            errors++;
            $display("FAIL basic_vld: got %b, expected 111", o_ph_vld);
        end
        checks++;
        if (o_dph !== {11'd0, 11'd10, 11'd0}) begin
            errors++;
            $display("FAIL basic_dph: got %h, expected %h", o_dph, {11'd0, 11'd10, 11'd0});
        end
        tick();
        checks++;
        if ({o_ph_en, o_busy} !== 2'b00 || o_ph !== e_ph) begin
            errors++;
            $display("FAIL basic_hold: got en=%b busy=%b ph=%h, expected 0 0 %h", o_ph_en, o_busy, o_ph, e_ph);
        end
    endtask

    task automatic test_neg_diff;
        int at;
        do_reset();
        go_to(2); i_dt[7:4] = 4'hF;
        go_to(5); i_dt[3:0] = 4'hF; i_dt[11:8] = 4'hF;
        wait_strobe(at);
        checks++;
        if (at != 18) begin
            errors++;
            $display("FAIL neg_latency: strobe at %0d, expected 18", at);
        end
        checks++;
        if (o_ph !== {10'd24, 10'd12, 10'd24} || o_ph_vld !== 3'b111) begin
            errors++;
            $display("FAIL neg_ph: got ph=%h vld=%b, expected %h 111", o_ph, o_ph_vld, {10'd24, 10'd12, 10'd24});
        end
        checks++;
        if (o_dph !== {11'd0, 11'h7F4, 11'd0}) begin
            errors++;
            $display("FAIL neg_dph: got %h, expected %h", o_dph, {11'd0, 11'h7F4, 11'd0});
        end
    endtask

    task automatic test_missing_lane;
        int at;
        do_reset();
        go_to(1); i_dt[3:0] = 4'hF;
        go_to(3); i_dt[7:4] = 4'hF;
        go_to(4); i_dt[8] = 1'b1; i_dt[10] = 1'b1; i_dt[11] = 1'b1;
        wait_strobe(at);
        checks++;
        if (at != 14) begin
            errors++;
            $display("FAIL miss_latency: strobe at %0d, expected 14", at);
        end
        checks++;
        if (o_ph !== {10'd15, 10'd16, 10'd8}) begin
            errors++;
            $display("FAIL miss_ph: got %h, expected %h", o_ph, {10'd15, 10'd16, 10'd8});
        end
        checks++;
        if (o_ph_vld !== 3'b011) begin
            errors++;
            $display("FAIL miss_vld: got %b, expected 011", o_ph_vld);
        end
        checks++;
        if (o_dph !== {11'd0, 11'd8, 11'd0}) begin
            errors++;
            $display("FAIL miss_dph: got %h, expected %h", o_dph, {11'd0, 11'd8, 11'd0});
        end
    endtask

    task automatic test_double_edge;
        int at;
        do_reset();
        go_to(1); i_dt[3:0] = 4'hF; i_dt[11:8] = 4'hF;
        go_to(3); i_dt[7:4] = 4'hF;
        go_to(4); i_dt[7:4] = 4'h0;
        go_to(5); i_dt[3:0] = 4'h0;
        go_to(7); i_dt[3:0] = 4'hF;
        go_to(8); i_dt[7:4] = 4'hF;
        wait_strobe(at);
        checks++;
        if (at != 14) begin
            errors++;
            $display("FAIL dbl_latency: strobe at %0d, expected 14", at);
        end
        checks++;
        if (o_ph !== {10'd8, 10'd16, 10'd8} || o_ph_vld !== 3'b111) begin
            errors++;
            $display("FAIL dbl_ph: got ph=%h vld=%b, expected %h 111", o_ph, o_ph_vld, {10'd8, 10'd16, 10'd8});
        end
        checks++;
        if (o_dph !== {11'd0, 11'd8, 11'd0}) begin
            errors++;
            $display("FAIL dbl_dph: got %h, expected %h", o_dph, {11'd0, 11'd8, 11'd0});
        end
    endtask

    task automatic test_saturation;
        int at;
        int seen;
        seen = 0;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if (o_ph_en !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL sat_idle: got %0d strobes busy=%b, expected 0 strobes busy=0", seen, o_busy);
        end
        i_dt = '1;
        tick();
        tick();
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL sat_busy: got %b, expected 1", o_busy);
        end
        wait_strobe(at);
        checks++;
        if (at != 313) begin
            errors++;
            $display("FAIL sat_latency: strobe at %0d, expected 313", at);
        end
        checks++;
        if (o_ph !== {10'd1020, 10'd1020, 10'd1020} || o_ph_vld !== 3'b111 || o_dph !== '0) begin
            errors++;
            $display("FAIL sat_result: got ph=%h vld=%b dph=%h, expected %h 111 0", o_ph, o_ph_vld, o_dph, {10'd1020, 10'd1020, 10'd1020});
        end
    endtask

    // Continues from the strobe cycle of test_saturation (i_dt still all ones).
    task automatic test_reset_mid_epoch;
        int at;
        next_epoch();
        i_dt = '0;
        go_to(2); i_dt[3:0] = 4'hF;
        go_to(6);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_busy: got %b, expected 1", o_busy);
        end
        i_res = 1'b1;
        i_dt  = '0;
        tick();
        checks++;
        if ({o_ph_en, o_busy, o_ph, o_ph_vld, o_dph} !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: got en=%b busy=%b ph=%h vld=%b dph=%h, expected all 0", o_ph_en, o_busy, o_ph, o_ph_vld, o_dph);
        end
        i_res = 1'b0;
        per   = 0;
        go_to(6); i_dt = '1;
        // Falling edges here sit inside WAIT and are ignored; they prepare a
        // fresh rising edge for the back-to-back epoch.
        go_to(10); i_dt = '0;
        wait_strobe(at);
        checks++;
        if (at != 19) begin
            errors++;
            $display("FAIL rst_latency: strobe at %0d, expected 19", at);
        end
        checks++;
        if (o_ph !== {10'd28, 10'd28, 10'd28} || o_ph_vld !== 3'b111 || o_dph !== '0) begin
            errors++;
            $display("FAIL rst_result: got ph=%h vld=%b dph=%h, expected %h 111 0", o_ph, o_ph_vld, o_dph, {10'd28, 10'd28, 10'd28});
        end
    endtask

    // Edge driven during the OUT cycle is seen in the first ARMED cycle and
    // captures counter value 0.
    task automatic test_back_to_back;
        int at;
        i_dt = '1;
        next_epoch();
        wait_strobe(at);
        checks++;
        if (at != 12) begin
            errors++;
            $display("FAIL b2b_latency: strobe at %0d, expected 12", at);
        end
        checks++;
        if (o_ph !== '0 || o_ph_vld !== 3'b111 || o_dph !== '0) begin
            errors++;
            $display("FAIL b2b_result: got ph=%h vld=%b dph=%h, expected 0 111 0", o_ph, o_ph_vld, o_dph);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_diff();
        test_missing_lane();
        test_double_edge();
        test_saturation();
        test_reset_mid_epoch();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
